// File: rtl/j1_dbus_io_pkg.sv
// rtl/j1_dbus_io_pkg.sv - register map, UART state and STAT bit definitions for j1_dbus_io
package j1_dbus_io_pkg;

    // Word offsets within the 8-word register window (adr[2:0]); 6 and 7 are reserved.
    typedef enum logic [2:0] {
        IO_GPIO_OUT  = 3'd0,
        IO_GPIO_IN   = 3'd1,
        IO_TICK_LO   = 3'd2,
        IO_TICK_HI   = 3'd3,
        IO_UART_DATA = 3'd4,
        IO_UART_STAT = 3'd5
    } io_reg_t;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    // Bit positions in the UART_STAT register.
    localparam int STAT_BUSY     = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_EMPTY    = 2;
    localparam int STAT_OVERFLOW = 3;

endpackage

// File: rtl/if_dbus.sv
// rtl/if_dbus.sv - J1 data bus: word address, read/write strobes, write and read data
interface if_dbus;
    logic [15:0] adr;
    logic        re;
    logic        we;
    logic [15:0] dat_o;
    logic [15:0] dat_i;

    modport master (output adr, re, we, dat_o, input dat_i);
    modport slave  (input adr, re, we, dat_o, output dat_i);
endinterface

// File: rtl/j1_dbus_io_uart_tx.sv
// rtl/j1_dbus_io_uart_tx.sv - 8N1 UART transmitter with a small byte FIFO in front
// Ports: clk, reset (sync, active high); push/din enqueue a byte;
//        full/empty FIFO status; busy = frame in progress; pop = FIFO read this cycle;
//        txd serial output, idle high.
module uart_tx
    import j1_dbus_io_pkg::*;
#(
    parameter int unsigned fifo_depth   = 4,
    parameter int unsigned clks_per_bit = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       pop,
    output logic       txd
);

    localparam int unsigned AW = $clog2(fifo_depth);
    localparam int unsigned BW = $clog2(clks_per_bit);

    logic [7:0]    mem [fifo_depth];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    uart_state_t   state;
    uart_state_t   state_nxt;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          baud_end;
    logic          push_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign baud_end = (baud == BW'(clks_per_bit - 1));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push && (!full || pop);
    assign busy     = (state != UART_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= UART_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        pop       = 1'b0;
        case (state)
            UART_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr[AW-1:0]];
                    baud_nxt  = '0;
                    state_nxt = UART_START;
                end
            end
            UART_START: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = UART_DATA;
                end else begin
                    baud_nxt = baud + BW'(1);
                end
            end
            UART_DATA: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nxt = UART_STOP;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud + BW'(1);
                end
            end
            UART_STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr[AW-1:0]];
                        state_nxt = UART_START;
                    end else begin
                        state_nxt = UART_IDLE;
                    end
                end else begin
                    baud_nxt = baud + BW'(1);
                end
            end
            default: begin
                state_nxt = UART_IDLE;
            end
        endcase
    end

    always_comb begin
        case (state)
            UART_START: txd = 1'b0;
            UART_DATA:  txd = shift[0];
            default:    txd = 1'b1;
        endcase
    end

endmodule

// File: rtl/j1_dbus_io.sv
// rtl/j1_dbus_io.sv - J1 data-bus I/O target: GPIO, 32-bit tick with snapshot, UART TX
// Ports: clk, reset (sync, active high); dbus slave side of the J1 data bus;
//        hit = address falls in the 8-word window; gpio_in async inputs;
//        gpio_out output register; uart_txd serial 8N1 output, idle high.
module j1_dbus_io
    import j1_dbus_io_pkg::*;
#(
    parameter logic [15:0] base_adr     = 16'h7F00,
    parameter int unsigned gpio_width   = 16,
    parameter int unsigned fifo_depth   = 4,
    parameter int unsigned clks_per_bit = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    if_dbus.slave                 dbus,
    output logic                  hit,
    input  logic [gpio_width-1:0] gpio_in,
    output logic [gpio_width-1:0] gpio_out,
    output logic                  uart_txd
);

    logic [2:0]            offset;
    logic                  wr_en;
    logic                  uart_push;
    logic                  ovf_clear;
    logic [gpio_width-1:0] gpio_meta;
    logic [gpio_width-1:0] gpio_sync;
    logic [31:0]           tick;
    logic [15:0]           snapshot;
    logic [15:0]           rd_data;
    logic [15:0]           dat_i_q;
    logic [15:0]           gpio_out_ext;
    logic [15:0]           gpio_in_ext;
    logic                  overflow;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_busy;
    logic                  tx_pop;

    assign hit          = (dbus.adr[15:3] == base_adr[15:3]);
    assign offset       = dbus.adr[2:0];
    assign wr_en        = dbus.we && hit;
    assign uart_push    = wr_en && (offset == IO_UART_DATA);
    assign ovf_clear    = wr_en && (offset == IO_UART_STAT) && dbus.dat_o[STAT_OVERFLOW];
    assign gpio_out_ext = 16'(gpio_out);
    assign gpio_in_ext  = 16'(gpio_sync);
    assign dbus.dat_i   = dat_i_q;

    always_comb begin
        rd_data = '0;
        case (offset)
            IO_GPIO_OUT: rd_data = gpio_out_ext;
            IO_GPIO_IN:  rd_data = gpio_in_ext;
            IO_TICK_LO:  rd_data = tick[15:0];
            IO_TICK_HI:  rd_data = snapshot;
            IO_UART_STAT: begin
                rd_data[STAT_BUSY]     = tx_busy;
                rd_data[STAT_FULL]     = tx_full;
                rd_data[STAT_EMPTY]    = tx_empty;
                rd_data[STAT_OVERFLOW] = overflow;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
            tick      <= '0;
            snapshot  <= '0;
            dat_i_q   <= '0;
            overflow  <= 1'b0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            tick      <= tick + 32'd1;
            if (wr_en && (offset == IO_GPIO_OUT)) begin
                gpio_out <= dbus.dat_o[gpio_width-1:0];
            end
            // Read data is sampled from pre-edge state, so a same-cycle write is not visible yet.
            if (dbus.re) begin
                dat_i_q <= hit ? rd_data : '0;
                // Latching the upper half with the low-half read keeps a 32-bit read coherent.
                if (hit && (offset == IO_TICK_LO)) begin
                    snapshot <= tick[31:16];
                end
            end
            if (uart_push && tx_full && !tx_pop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    uart_tx #(
        .fifo_depth   (fifo_depth),
        .clks_per_bit (clks_per_bit)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .push  (uart_push),
        .din   (dbus.dat_o[7:0]),
        .full  (tx_full),
        .empty (tx_empty),
        .busy  (tx_busy),
        .pop   (tx_pop),
        .txd   (uart_txd)
    );

endmodule

// File: doc/j1_dbus_io.md
Name: j1_dbus_io

Overview:
Memory-mapped I/O responder on the J1 data bus; it is the target end of the transactions the core initiates on if_dbus.
Decodes an 8-word window and provides GPIO, a 32-bit cycle counter with coherent snapshot, and a UART transmitter with a small FIFO.
Sits beside data RAM at top level; its read data is zero outside its window so top level ORs it with RAM data.

Parameters:
base_adr, 16'h7F00, word address of register window; bits [2:0] must be 0
gpio_width, 16, width of gpio_in/gpio_out (1..16)
fifo_depth, 4, UART TX FIFO entries; power of 2, 2..16
clks_per_bit, 434, clk cycles per UART bit (50 MHz / 115200); >= 2

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
dbus  if_dbus.slave  -  adr[15:0] word address, re, we, dat_o[15:0] write data from core, dat_i[15:0] read data to core
hit  output  1  combinational: adr[15:3] == base_adr[15:3]
gpio_in  input  gpio_width  asynchronous inputs
gpio_out  output  gpio_width  GPIO output register
uart_txd  output  1  serial 8N1 output, idle high

Behaviour:
- Reset (sync, one clk edge): gpio_out=0, dbus.dat_i=0, uart_txd=1, FIFO empty, overflow=0, tick=0, snapshot=0, TX FSM IDLE.
- Register map, offset = adr[2:0]:
  0 GPIO_OUT rw; 1 GPIO_IN ro, after 2-flop synchroniser, upper bits 0;
  2 TICK_LO ro, read also latches tick[31:16] into snapshot;
  3 TICK_HI ro, returns snapshot;
  4 UART_DATA wo, write pushes dat_o[7:0];
  5 UART_STAT: bit0 tx_busy, bit1 full, bit2 empty, bit3 overflow (sticky), others 0; writing 1 to bit3 clears it;
  6-7 reserved, read 0, writes ignored.
- Write: committed on the edge where we=1 and hit=1. Write-only/read-only violations are ignored.
- Read: registered, 1-cycle latency. On the edge where re=1, dat_i <= selected value, or 0 if !hit. dat_i holds until the next re. The core samples dat_i in its wait cycle.
- re and we in the same cycle: write takes effect; read returns the pre-write value.
- tick: 32-bit, +1 every cycle, wraps 32'hFFFFFFFF -> 0. TICK_LO returns the value at the read edge; snapshot captured on the same edge.
- FIFO: fifo_depth entries, pointers with extra wrap bit.
  - Push while full: data dropped, overflow set.
  - Push while full with a pop in the same cycle: pop first, push accepted, no overflow.
  - Pop when the TX FSM leaves IDLE.
- TX FSM IDLE/START/DATA/STOP; baud counter counts 0..clks_per_bit-1, bit counter 0..7.
  - IDLE: txd=1; !empty -> pop byte into shift reg, go START.
  - START: txd=0 for clks_per_bit cycles.
  - DATA: LSB first, 8 bits each clks_per_bit cycles.
  - STOP: txd=1 for clks_per_bit cycles -> IDLE. Back-to-back frames need no extra idle cycle if FIFO is non-empty.
  - tx_busy = state != IDLE.
- Reset mid-frame: txd=1 the cycle after the reset edge; queued bytes are discarded.

Decomposition:
- Package types gains: io_reg_t enum (IO_GPIO_OUT=0 .. IO_UART_STAT=5), uart_state_t enum (UART_IDLE, UART_START, UART_DATA, UART_STOP), STAT bit index constants.
- Sub-module uart_tx (FIFO plus FSM). Params fifo_depth, clks_per_bit. Ports: clk, reset, push, din[7:0], full, empty, busy, txd.
- Decode, GPIO, tick and overflow logic stay in j1_dbus_io.

Test Plan (bench uses clks_per_bit=4, fifo_depth=4, base_adr=16'h7F00):
- Write 16'hA5C3 to 7F00, then re at 7F00 -> gpio_out=16'hA5C3 after write edge; dat_i=16'hA5C3 one cycle after re. Re at 1234 -> dat_i=0, hit=0.
- Drive gpio_in=16'h00F0, read 7F01 >=3 cycles later -> 16'h00F0. Read 7F01 one cycle after change -> old value.
- Force tick=32'h0001_FFFF before reading 7F02, read 7F03 five cycles later -> LO=16'hFFFF, HI=16'h0001 (not 0002).
- Write 8'h55 to 7F04 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each held 4 clks. STAT reads busy=1 during the frame, 16'h0004 after.
- Burst 6 writes to 7F04 while idle -> first popped immediately, 4 queued, 6th dropped; STAT=16'h000B. Write 16'h0008 to 7F05 -> overflow cleared. Five frames sent back-to-back.
- Assert reset during DATA bit 3 of a frame -> txd=1, STAT=16'h0004, gpio_out=0, dat_i=0 after the reset edge; a new write transmits normally.
